// File: rtl/win_banner_ctrl.sv
// Win banner controller: slides a banner down to TARGET_Y, blinks it, then holds until dismissed.
// Define WIN_BANNER_SCALE2_EN for a pixel-doubled 128x32 footprint (default 64x16).
module win_banner_ctrl #(
  parameter logic [10:0] X_POS        = 11'd288,
  parameter logic [10:0] TARGET_Y     = 11'd232,
  parameter logic [10:0] SLIDE_STEP   = 11'd4,
  parameter logic [7:0]  BLINK_PERIOD = 8'd15,
  parameter logic [3:0]  BLINK_COUNT  = 4'd6
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        winEvent,
  input  logic        clearBanner,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic        bannerActive,
  output logic        bannerDone
);

`ifdef WIN_BANNER_SCALE2_EN
  localparam logic [11:0] W = 12'd128;
  localparam logic [11:0] H = 12'd32;
`else
  localparam logic [11:0] W = 12'd64;
  localparam logic [11:0] H = 12'd16;
`endif

  typedef enum logic [1:0] {IDLE, SLIDE, BLINK, HOLD} state_t;

  state_t      state_q;
  logic [10:0] topY_q;
  logic        visible_q;
  logic [7:0]  frame_q;
  logic [3:0]  toggle_q;
  logic        done_q;
  logic        inside_q;
  logic [10:0] offsetX_q;
  logic [10:0] offsetY_q;

  logic [11:0] slide_sum;
  logic [10:0] topY_d;
  logic [7:0]  frame_d;
  logic [3:0]  toggle_d;
  logic        in_x;
  logic        in_y;
  logic        inside_d;
  logic [10:0] dx;
  logic [10:0] dy;
  logic [10:0] offsetX_d;
  logic [10:0] offsetY_d;

  // 12-bit sums keep the slide clamp and the footprint bounds from wrapping.
  assign slide_sum = {1'b0, topY_q} + {1'b0, SLIDE_STEP};
  assign topY_d    = (slide_sum >= {1'b0, TARGET_Y}) ? TARGET_Y : slide_sum[10:0];
  assign frame_d   = frame_q + 8'd1;
  assign toggle_d  = toggle_q + 4'd1;

  assign in_x = ({1'b0, pixelX} >= {1'b0, X_POS}) && ({1'b0, pixelX} < ({1'b0, X_POS} + W));
  assign in_y = ({1'b0, pixelY} >= {1'b0, topY_q}) && ({1'b0, pixelY} < ({1'b0, topY_q} + H));
  assign inside_d = in_x && in_y && visible_q && (state_q != IDLE);

  assign dx = pixelX - X_POS;
  assign dy = pixelY - topY_q;

`ifdef WIN_BANNER_SCALE2_EN
  // Halving the offset replays each bitmap texel over a 2x2 pixel block.
  assign offsetX_d = inside_d ? {1'b0, dx[10:1]} : 11'd0;
  assign offsetY_d = inside_d ? {1'b0, dy[10:1]} : 11'd0;
`else
  assign offsetX_d = inside_d ? dx : 11'd0;
  assign offsetY_d = inside_d ? dy : 11'd0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      topY_q    <= 11'd0;
      visible_q <= 1'b0;
      frame_q   <= 8'd0;
      toggle_q  <= 4'd0;
      done_q    <= 1'b0;
      inside_q  <= 1'b0;
      offsetX_q <= 11'd0;
      offsetY_q <= 11'd0;
    end else begin
      done_q    <= 1'b0;
      inside_q  <= inside_d;
      offsetX_q <= offsetX_d;
      offsetY_q <= offsetY_d;
      if (state_q != IDLE && clearBanner) begin
        state_q   <= IDLE;
        visible_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (winEvent) begin
            state_q   <= SLIDE;
            topY_q    <= 11'd0;
            visible_q <= 1'b1;
          end
          SLIDE: if (startOfFrame) begin
            topY_q <= topY_d;
            if (topY_d == TARGET_Y) begin
              state_q  <= BLINK;
              frame_q  <= 8'd0;
              toggle_q <= 4'd0;
            end
          end
          BLINK: if (startOfFrame) begin
            if (frame_d == BLINK_PERIOD) begin
              frame_q   <= 8'd0;
              toggle_q  <= toggle_d;
              visible_q <= ~visible_q;
              if (toggle_d == BLINK_COUNT) begin
                state_q   <= HOLD;
                visible_q <= 1'b1;
                done_q    <= 1'b1;
              end
            end else begin
              frame_q <= frame_d;
            end
          end
          HOLD: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign offsetX         = offsetX_q;
  assign offsetY         = offsetY_q;
  assign InsideRectangle = inside_q;
  assign bannerActive    = (state_q != IDLE);
  assign bannerDone      = done_q;

endmodule

// File: tb/tb_win_banner_ctrl.sv
// Scoreboard bench for win_banner_ctrl: a frame-count reference model predicts each cycle's outputs.
module tb_win_banner_ctrl;

  localparam int XP = 288;
  localparam int TY = 232;
  localparam int ST = 4;
  localparam int BP = 15;
  localparam int BC = 6;
`ifdef WIN_BANNER_SCALE2_EN
  localparam int W  = 128;
  localparam int H  = 32;
  localparam int SC = 1;
`else
  localparam int W  = 64;
  localparam int H  = 16;
  localparam int SC = 0;
`endif

  typedef struct packed {
    logic        ins;
    logic [10:0] ox;
    logic [10:0] oy;
    logic        act;
    logic        done;
  } obs_t;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        startOfFrame = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        winEvent = 1'b0;
  logic        clearBanner = 1'b0;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic        bannerActive;
  logic        bannerDone;

  int errors = 0;
  int checks = 0;
  obs_t exp_q[$];

  // Reference model: banner life measured in frames since the win was accepted.
  bit m_act = 1'b0;
  int m_n   = 0;

  win_banner_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .winEvent(winEvent), .clearBanner(clearBanner),
    .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
    .bannerActive(bannerActive), .bannerDone(bannerDone)
  );

  always #5 clk = ~clk;

  function automatic int slide_frames();
    int k = (TY + ST - 1) / ST;
    return (k < 1) ? 1 : k;
  endfunction

  function automatic int hold_frame();
    return slide_frames() + BC * BP;
  endfunction

  function automatic int top_y(input int n);
    return (n * ST < TY) ? n * ST : TY;
  endfunction

  function automatic bit vis(input int n);
    int t;
    if (n < slide_frames()) return 1'b1;
    t = (n - slide_frames()) / BP;
    if (t >= BC) return 1'b1;
    return (t % 2) == 0;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = {InsideRectangle, offsetX, offsetY, bannerActive, bannerDone};
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got ins=%b ox=%0d oy=%0d act=%b done=%b, expected ins=%b ox=%0d oy=%0d act=%b done=%b",
               name, $time, got.ins, got.ox, got.oy, got.act, got.done,
               want.ins, want.ox, want.oy, want.act, want.done);
    end
  endtask

  // Monitor: every post-edge sample is compared against the oldest prediction.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", observe(), e);
      end
    end
  end

  task automatic step(input bit win, input bit clr, input bit sof,
                      input logic [10:0] px, input logic [10:0] py);
    obs_t e;
    int   ty;
    bit   hit;
    @(negedge clk);
    winEvent = win; clearBanner = clr; startOfFrame = sof;
    pixelX = px; pixelY = py;
    ty  = top_y(m_n);
    hit = m_act && vis(m_n) && int'(px) >= XP && int'(px) < XP + W &&
          int'(py) >= ty && int'(py) < ty + H;
    e.ins  = hit;
    e.ox   = hit ? 11'((int'(px) - XP) >> SC) : 11'd0;
    e.oy   = hit ? 11'((int'(py) - ty) >> SC) : 11'd0;
    e.done = 1'b0;
    if (m_act && clr) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (win) begin
        m_act = 1'b1;
        m_n   = 0;
      end
    end else if (sof && m_n < hold_frame()) begin
      m_n++;
      if (m_n == hold_frame()) e.done = 1'b1;
    end
    e.act = m_act;
    exp_q.push_back(e);
  endtask

  function automatic logic [10:0] rand_px();
    if ($urandom_range(0, 7) == 0) return 11'($urandom);
    return 11'(XP - 8 + int'($urandom_range(0, W + 16)));
  endfunction

  function automatic logic [10:0] rand_py();
    int v;
    if ($urandom_range(0, 7) == 0) return 11'($urandom);
    v = top_y(m_n) - 4 + int'($urandom_range(0, H + 8));
    return 11'((v < 0) ? 0 : v);
  endfunction

  // k start-of-frame pulses, each preceded by a short random gap of mid-frame pixels.
  task automatic run_sofs(input int k);
    for (int i = 0; i < k; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++)
        step($urandom_range(0, 19) == 0, 1'b0, 1'b0, rand_px(), rand_py());
      step(1'b0, 1'b0, 1'b1, rand_px(), rand_py());
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetN = 1'b0;
    winEvent = 1'b0; clearBanner = 1'b0; startOfFrame = 1'b0;
    #1;
    check("reset_outputs", observe(), '0);
    m_act = 1'b0;
    m_n   = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_held", observe(), '0);
    resetN = 1'b1;
  endtask

  initial begin
    pulse_reset();
    repeat (2) step(1'b0, 1'b0, 1'b0, rand_px(), rand_py());

    // Win with a coincident frame pulse, slide to target, blink, hold.
    step(1'b1, 1'b0, 1'b1, rand_px(), rand_py());
    run_sofs(slide_frames());
    run_sofs(BC * BP);
    repeat (3) step(1'b1, 1'b0, 1'b0, rand_px(), rand_py());
    step(1'b0, 1'b0, 1'b0, 11'd300, 11'd240);
    step(1'b0, 1'b0, 1'b0, 11'd352, 11'd240);
    step(1'b0, 1'b0, 1'b0, 11'd351, 11'd263);
    step(1'b0, 1'b0, 1'b0, 11'd287, 11'd240);
    step(1'b0, 1'b0, 1'b1, 11'd288, 11'd232);
    step(1'b0, 1'b1, 1'b0, 11'd300, 11'd240);
    repeat (3) step(1'b0, 1'b0, 1'b0, 11'd300, 11'd240);

    // Dismiss mid-slide on the same cycle as a frame pulse.
    step(1'b1, 1'b0, 1'b0, rand_px(), rand_py());
    run_sofs(10);
    step(1'b0, 1'b1, 1'b1, rand_px(), rand_py());
    repeat (3) step(1'b0, 1'b0, 1'b1, 11'd300, 11'd40);

    // Reset in the middle of the blink, then a fresh slide from the top.
    step(1'b1, 1'b0, 1'b0, rand_px(), rand_py());
    run_sofs(slide_frames() + 40);
    pulse_reset();
    step(1'b1, 1'b0, 1'b0, rand_px(), rand_py());
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, 11'(XP + 5), 11'(top_y(m_n) + 3));
      step(1'b0, 1'b0, 1'b1, rand_px(), rand_py());
    end
    step(1'b0, 1'b1, 1'b0, rand_px(), rand_py());

    // Random mix of wins, dismissals and frame pulses.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 29) == 0, $urandom_range(0, 299) == 0,
           $urandom_range(0, 2) == 0, rand_px(), rand_py());

    step(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
